// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Both the fetch queue and its FIFO import this package.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'd100;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Fetches are word-granular, so the low two address bits are always zero.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~(PC_W'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
// Flush wins over push and pop in the same cycle; the head is read straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head,
  output logic               head_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign pop_ok  = pop && head_valid;
  assign push_ok = push && ((count < CNT_W'(DEPTH)) || pop_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps one memory request in flight,
// and queues returned words with their PCs for decode. Redirect flushes and restarts.
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  req_pc;
  logic             outstanding;
  logic             drop;

  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             head_valid;
  logic             pop;
  logic             push;
  logic             issue;
  logic [OCC_W-1:0] occupancy;

  // Decode handshake: inst_valid means the head entry is stable and held until
  // taken; the entry is consumed only in a cycle where inst_valid && inst_ready.
  assign pop = head_valid && inst_ready;

  // Occupancy reserves a slot for the in-flight response so the queue cannot overflow.
  assign occupancy = OCC_W'(count) + OCC_W'(outstanding) - OCC_W'(pop);

  assign issue = !reset && !redirect && (!outstanding || imem_rvalid)
                 && (occupancy < OCC_W'(DEPTH));

  assign push       = imem_rvalid && outstanding && !drop;
  assign push_entry = '{pc: req_pc, inst: imem_rdata};

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= align_pc(redirect_pc);
      // The in-flight response, if any, must be swallowed when it eventually arrives.
      if (outstanding && !imem_rvalid) begin
        drop <= 1'b1;
      end else if (imem_rvalid) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
    end else begin
      if (imem_rvalid && outstanding) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
      if (issue) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head),
    .head_valid (head_valid)
  );

  assign inst_valid = head_valid;
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a variable-latency memory responder plus a queue-based
// reference model of the fetch queue, driven by directed scenarios and random traffic.
module tb_if_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'd100;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // memory responder
  int          lat_min = 1;
  int          lat_max = 1;
  bit          m_pend;
  int          m_cnt;
  logic [31:0] m_addr;

  // reference model: expected queue contents {pc, inst}, fetch PC, in-flight state
  logic [63:0] exp_q[$];
  logic [31:0] md_pc;
  logic [31:0] md_req_pc;
  bit          md_out;
  bit          md_drop;

  logic [31:0] pop_log[$];
  logic [31:0] req_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    md_pc     = RPC;
    md_req_pc = '0;
    md_out    = 1'b0;
    md_drop   = 1'b0;
    exp_q.delete();
    m_pend    = 1'b0;
    m_cnt     = 0;
  endtask

  // Asserts reset asynchronously, checks reset outputs, releases just after an edge.
  task automatic do_reset(input int cycles);
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = $urandom;
    model_reset();
    #1;
    check_eq("rst_imem_req", imem_req, 0);
    check_eq("rst_imem_addr", imem_addr, RPC);
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_inst_data", inst_data, 0);
    check_eq("rst_inst_pc", inst_pc, 0);
    repeat (cycles) @(posedge clk);
    #1;
    reset       = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic run_cycle(input bit rd, input logic [31:0] rdpc, input bit rdy, input bit spur);
    bit          rv;
    bit          e_valid;
    bit          e_pop;
    bit          e_req;
    int          occ;
    logic [31:0] rdat;
    logic [63:0] head;

    rv = 1'b0;
    if (m_pend) begin
      m_cnt--;
      if (m_cnt <= 0) rv = 1'b1;
    end else if (spur) begin
      rv = 1'b1;
    end
    rdat = m_pend ? mem_word(m_addr) : $urandom;

    imem_rvalid = rv;
    imem_rdata  = rdat;
    redirect    = rd;
    redirect_pc = rdpc;
    inst_ready  = rdy;
    #1;

    e_valid = (exp_q.size() != 0);
    e_pop   = e_valid && rdy;
    occ     = exp_q.size() + int'(md_out) - int'(e_pop);
    e_req   = !rd && (!md_out || rv) && (occ < DEPTH);

    check_eq("imem_req", imem_req, e_req);
    check_eq("imem_addr", imem_addr, md_pc);
    check_eq("inst_valid", inst_valid, e_valid);
    if (e_valid) begin
      head = exp_q[0];
      check_eq("inst_pc", inst_pc, head[63:32]);
      check_eq("inst_data", inst_data, head[31:0]);
    end

    if (inst_valid && rdy && !rd) pop_log.push_back(inst_pc);
    if (imem_req) req_log.push_back(imem_addr);

    if (rd) begin
      exp_q.delete();
      md_pc = rdpc & ~32'd3;
      if (md_out && !rv) begin
        md_drop = 1'b1;
      end else if (rv) begin
        md_out  = 1'b0;
        md_drop = 1'b0;
      end
    end else begin
      if (e_pop) void'(exp_q.pop_front());
      if (rv && md_out) begin
        if (!md_drop) exp_q.push_back({md_req_pc, rdat});
        md_out  = 1'b0;
        md_drop = 1'b0;
      end
      if (e_req) begin
        md_out    = 1'b1;
        md_req_pc = md_pc;
        md_pc     = md_pc + 32'd4;
      end
    end

    if (rv && m_pend) m_pend = 1'b0;
    if (imem_req) begin
      m_pend = 1'b1;
      m_addr = imem_addr;
      m_cnt  = $urandom_range(lat_max, lat_min);
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    int  idx;
    int  first_valid;
    bit  found;

    // Streaming at latency 1: first instruction visible two cycles after release.
    lat_min = 1; lat_max = 1;
    do_reset(3);
    pop_log.delete(); req_log.delete();
    first_valid = -1;
    for (int c = 0; c < 12; c++) begin
      if (first_valid < 0 && inst_valid) first_valid = c;
      run_cycle(0, 0, 1, 0);
    end
    check_eq("first_valid_cycle", first_valid, 2);
    for (int i = 0; i < 4; i++) begin
      check_eq("stream_req_addr", req_log[i], RPC + 32'(4 * i));
      check_eq("stream_pop_pc", pop_log[i], RPC + 32'(4 * i));
    end

    // Decode stall for 10 cycles fills the queue, then drains in order.
    do_reset(2);
    pop_log.delete(); req_log.delete();
    for (int c = 0; c < 10; c++) run_cycle(0, 0, 0, 0);
    check_eq("stall_req_low", imem_req, 0);
    check_eq("stall_req_count", req_log.size(), DEPTH);
    for (int c = 0; c < 10; c++) run_cycle(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) check_eq("drain_pc", pop_log[i], RPC + 32'(4 * i));

    // Redirect while the request for 108 is in flight with latency 3.
    lat_min = 3; lat_max = 3;
    do_reset(2);
    pop_log.delete(); req_log.delete();
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (md_out && md_req_pc == 32'd108 && m_cnt >= 2) found = 1'b1;
      else run_cycle(0, 0, 1, 0);
    end
    check_eq("reach_108_inflight", found, 1);
    idx = pop_log.size();
    run_cycle(1, 32'h200, 1, 0);
    for (int c = 0; c < 12; c++) run_cycle(0, 0, 1, 0);
    check_eq("after_redirect_pc", pop_log[idx], 32'h200);

    // Redirect coinciding with a response and a pop at latency 1.
    lat_min = 1; lat_max = 1;
    do_reset(2);
    for (int c = 0; c < 6; c++) run_cycle(0, 0, 1, 0);
    req_log.delete();
    run_cycle(1, 32'h340, 1, 0);
    check_eq("redir_empty", inst_valid, 0);
    run_cycle(0, 0, 1, 0);
    check_eq("redir_next_fetch", req_log[0], 32'h340);

    // PC wrap and low-bit forcing.
    req_log.delete();
    run_cycle(1, 32'hFFFF_FFFC, 1, 0);
    for (int c = 0; c < 4; c++) run_cycle(0, 0, 1, 0);
    check_eq("wrap_addr0", req_log[0], 32'hFFFF_FFFC);
    check_eq("wrap_addr1", req_log[1], 32'h0000_0000);
    req_log.delete();
    run_cycle(1, 32'h203, 1, 0);
    for (int c = 0; c < 3; c++) run_cycle(0, 0, 1, 0);
    check_eq("align_addr", req_log[0], 32'h200);

    // Spurious responses against a full queue with nothing outstanding.
    do_reset(2);
    pop_log.delete();
    for (int c = 0; c < 8; c++) run_cycle(0, 0, 0, 0);
    for (int c = 0; c < 4; c++) run_cycle(0, 0, 0, 1);
    check_eq("spur_valid", inst_valid, 1);
    check_eq("spur_head_pc", inst_pc, RPC);
    for (int c = 0; c < 8; c++) run_cycle(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) check_eq("spur_drain_pc", pop_log[i], RPC + 32'(4 * i));

    // Random traffic with a mid-run reset.
    lat_min = 1; lat_max = 4;
    do_reset(2);
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        do_reset(2);
      end else begin
        run_cycle(($urandom_range(99, 0) < 3), $urandom,
                  ($urandom_range(99, 0) < 70), ($urandom_range(99, 0) < 10));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
